// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU: opcode and phase encodings,
// phase-counter sizing and the ALU-opcode classifier.
package cpu_pkg;

  localparam int PHASE_W = 3;
  localparam int PHASES  = 8;

  typedef enum logic [2:0] {
    HLT = 3'd0,
    SKZ = 3'd1,
    ADD = 3'd2,
    AND = 3'd3,
    XOR = 3'd4,
    LDA = 3'd5,
    STO = 3'd6,
    JMP = 3'd7
  } opcode_t;

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_t;

  // Opcodes that read an operand from memory into the accumulator.
  function automatic logic is_aluop(opcode_t op);
    return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
  endfunction

endpackage

// File: rtl/cpu_sequencer_phase_counter.sv
// Phase counter for the instruction sequencer.
// Ports:
//   clk    - clock, rising edge
//   rst_   - asynchronous reset, active-low (phase -> INST_ADDR)
//   en     - advance enable; phase holds when 0
//   freeze - holds the phase regardless of en (used for halt)
//   phase  - current phase, registered
module phase_counter
  import cpu_pkg::*;
#(
  parameter int PHASES  = 8,
  parameter int PHASE_W = 3
) (
  input  logic   clk,
  input  logic   rst_,
  input  logic   en,
  input  logic   freeze,
  output phase_t phase
);

  localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(PHASES - 1);

  phase_t phase_nxt;

  always_comb begin
    phase_nxt = phase;
    if (en && !freeze) begin
      if (phase == phase_t'(LAST_PHASE))
        phase_nxt = INST_ADDR;
      else
        phase_nxt = phase_t'(phase + 3'd1);
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_)
      phase <= INST_ADDR;
    else
      phase <= phase_nxt;
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Eight-phase instruction sequencer for the 8-bit CPU. Drives the IR,
// accumulator and PC enables plus the memory strobes from the registered
// phase, the live opcode and the ALU zero flag.
// Ports:
//   clk, rst_          - clock (rising) and async active-low reset
//   en                 - phase-advance enable
//   opcode, zero       - instruction opcode and accumulator-zero flag
//   phase              - current phase
//   mem_rd, mem_wr     - memory read / write strobes
//   load_ir, load_ac   - instruction register / accumulator enables
//   load_pc, inc_pc    - PC jump load / PC increment
//   halt               - CPU halted
//
// phase      | meaning
// -----------+-----------------------------------------------
// INST_ADDR  | PC drives address bus, no strobes
// INST_FETCH | read instruction
// INST_LOAD  | read instruction, load IR
// IDLE       | hold IR load while bus settles
// OP_ADDR    | increment PC; HLT stops here
// OP_FETCH   | read operand for ALU ops
// ALU_OP     | load ACC; SKZ skip; JMP load PC
// STORE      | finish ACC load; STO writes; JMP completes
// (halted)   | phase frozen at OP_ADDR, only halt asserted
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int PHASES  = 8,
  parameter int PHASE_W = 3
) (
  input  logic               clk,
  input  logic               rst_,
  input  logic               en,
  input  logic [2:0]         opcode,
  input  logic               zero,
  output logic [PHASE_W-1:0] phase,
  output logic               mem_rd,
  output logic               mem_wr,
  output logic               load_ir,
  output logic               load_ac,
  output logic               load_pc,
  output logic               inc_pc,
  output logic               halt
);

  opcode_t op;
  phase_t  phase_q;
  logic    halted;
  logic    hlt_now;
  logic    alu;

  assign op  = opcode_t'(opcode);
  assign alu = is_aluop(op);

  // Phase compare is first so an unknown opcode outside OP_ADDR cannot
  // reach the freeze or halt logic.
  assign hlt_now = (phase_q == OP_ADDR) && (op == HLT);

  phase_counter #(
    .PHASES  (PHASES),
    .PHASE_W (PHASE_W)
  ) u_phase_counter (
    .clk    (clk),
    .rst_   (rst_),
    .en     (en),
    .freeze (halted | hlt_now),
    .phase  (phase_q)
  );

  assign phase = phase_q;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_)
      halted <= 1'b0;
    else if (en && hlt_now)
      halted <= 1'b1;
  end

  always_comb begin
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    load_ir = 1'b0;
    load_ac = 1'b0;
    load_pc = 1'b0;
    inc_pc  = 1'b0;
    halt    = 1'b0;
    if (halted) begin
      halt = 1'b1;
    end else begin
      case (phase_q)
        INST_ADDR: ;
        INST_FETCH: mem_rd = 1'b1;
        INST_LOAD: begin
          mem_rd  = 1'b1;
          load_ir = 1'b1;
        end
        IDLE: begin
          mem_rd  = 1'b1;
          load_ir = 1'b1;
        end
        OP_ADDR: begin
          inc_pc = 1'b1;
          halt   = (op == HLT);
        end
        OP_FETCH: mem_rd = alu;
        ALU_OP: begin
          mem_rd  = alu;
          load_ac = alu;
          inc_pc  = (op == SKZ) && zero;
          load_pc = (op == JMP);
        end
        STORE: begin
          mem_rd  = alu;
          load_ac = alu;
          // Both PC controls assert on JMP; load_pc wins downstream.
          inc_pc  = (op == JMP);
          load_pc = (op == JMP);
          mem_wr  = (op == STO);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
module tb_cpu_sequencer;

  logic       clk = 1'b0;
  logic       rst_ = 1'b0;
  logic       en = 1'b0;
  logic [2:0] opcode = 3'd0;
  logic       zero = 1'b0;
  logic [2:0] phase;
  logic       mem_rd, mem_wr, load_ir, load_ac, load_pc, inc_pc, halt;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  int m_phase  = 0;
  bit m_halted = 0;

  cpu_sequencer dut (
    .clk     (clk),
    .rst_    (rst_),
    .en      (en),
    .opcode  (opcode),
    .zero    (zero),
    .phase   (phase),
    .mem_rd  (mem_rd),
    .mem_wr  (mem_wr),
    .load_ir (load_ir),
    .load_ac (load_ac),
    .load_pc (load_pc),
    .inc_pc  (inc_pc),
    .halt    (halt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (model phase %0d op %0d zero %0b)",
               tag, obs, exp, m_phase, opcode, zero);
    end
  endtask

  // Expected {mem_rd, mem_wr, load_ir, load_ac, load_pc, inc_pc, halt}
  function automatic logic [6:0] exp_out(int ph, int op, bit z, bit hlt);
    bit alu;
    logic [6:0] r;
    alu = (op >= 2 && op <= 5);
    if (hlt) return 7'b0000001;
    r[6] = (ph >= 1 && ph <= 3) || (ph >= 5 && alu);
    r[5] = (ph == 7) && (op == 6);
    r[4] = (ph == 2) || (ph == 3);
    r[3] = (ph >= 6) && alu;
    r[2] = (ph >= 6) && (op == 7);
    r[1] = (ph == 4) || (ph == 6 && op == 1 && z) || (ph == 7 && op == 7);
    r[0] = (ph == 4) && (op == 0);
    return r;
  endfunction

  task automatic check_all();
    check("phase", int'(phase), m_phase);
    check("strobes", int'({mem_rd, mem_wr, load_ir, load_ac, load_pc, inc_pc, halt}),
          int'(exp_out(m_phase, int'(opcode), zero, m_halted)));
    check("rd_wr_excl", int'(mem_rd & mem_wr), 0);
    check("pc_excl", int'(load_pc & inc_pc & (phase != 3'd7)), 0);
  endtask

  task automatic tick();
    @(posedge clk);
    if (!m_halted && en) begin
      if (m_phase == 4 && opcode == 3'd0) m_halted = 1;
      else m_phase = (m_phase + 1) % 8;
    end
    #1;
    check_all();
  endtask

  // Asynchronous reset applied between clock edges; checks outputs settle
  // before any clock edge, then releases away from the rising edge.
  task automatic do_reset();
    rst_ = 1'b0;
    #1;
    m_phase  = 0;
    m_halted = 0;
    check_all();
    @(negedge clk);
    rst_ = 1'b1;
    #1;
    check_all();
  endtask

  task automatic run_op(input int op, input bit z, input int n);
    opcode = 3'(op);
    zero   = z;
    repeat (n) tick();
  endtask

  int hold_cnt;

  initial begin
    #2;
    m_phase = 0;
    check_all();
    do_reset();
    en = 1'b1;

    run_op(2, 0, 8);   // ADD
    run_op(6, 0, 8);   // STO
    run_op(1, 1, 8);   // SKZ, zero
    run_op(1, 0, 8);   // SKZ, nonzero
    run_op(7, 0, 8);   // JMP

    // stall at IDLE
    run_op(2, 0, 3);
    en = 1'b0;
    repeat (5) tick();
    check("stall_load_ir", int'(load_ir), 1);
    en = 1'b1;
    tick();
    check("stall_resume", int'(phase), 4);
    repeat (4) tick();

    // reset during STO write
    run_op(6, 0, 7);
    check("sto_wr_before", int'(mem_wr), 1);
    do_reset();
    check("sto_wr_after", int'(mem_wr), 0);

    // halt and recovery
    en = 1'b1;
    run_op(0, 0, 4);
    check("hlt_at_4", int'(halt), 1);
    repeat (20) tick();
    check("hlt_frozen", int'(phase), 4);
    en = 1'b0;
    repeat (2) tick();
    do_reset();
    check("hlt_cleared", int'(halt), 0);

    // randomized run; opcode/zero only change in phases 0-3
    hold_cnt = 0;
    for (int i = 0; i < 800; i++) begin
      if (m_phase <= 3) begin
        if ($urandom_range(0, 15) == 0) opcode = 3'd0;
        else opcode = 3'($urandom_range(1, 7));
        zero = 1'($urandom);
      end
      en = ($urandom_range(0, 3) != 0);
      hold_cnt = m_halted ? hold_cnt + 1 : 0;
      if (hold_cnt > 6 || $urandom_range(0, 59) == 0) begin
        do_reset();
        hold_cnt = 0;
      end else begin
        tick();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
